// File: rtl/store_unit.sv
// Store unit: sb/sh/sw into a word-wide memory without byte enables; sw in 1 cycle, sb/sh via 3-cycle read-modify-write.
// Stalls the requester by dropping req_ready while busy. Optional STORE_MISALIGN_CHECK_EN rejects misaligned/illegal requests.
module store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        storeCtrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
`ifdef STORE_MISALIGN_CHECK_EN
        S_WRITE,
        S_FAIL
`else
        S_WRITE
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic                r_is_sb;
    logic                w_accept;
    logic                w_rmw;
    logic [31:0]         w_merged;
    logic [ADDR_W-1:0]   w_word_addr;

    assign w_accept    = req_valid && req_ready;
    assign w_rmw       = (storeCtrl == 3'b000) || (storeCtrl == 3'b001);
    assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_MISALIGN_CHECK_EN
    logic w_reject;
    assign w_reject = (storeCtrl > 3'b010)
                   || ((storeCtrl == 3'b001) && addr[0])
                   || ((storeCtrl == 3'b010) && (addr[1:0] != 2'b00));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef STORE_MISALIGN_CHECK_EN
                    if (w_reject)
                        w_next = S_FAIL;
                    else
`endif
                    if (w_rmw)
                        w_next = S_READ;
                    else
                        w_next = S_WRITE;
                end
            end
            S_READ:  w_next = S_MERGE;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
`ifdef STORE_MISALIGN_CHECK_EN
            S_FAIL:  w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // r_data holds wd until MERGE, then the merged word; WRITE always drives r_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_is_sb <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= addr;
            r_data  <= wd;
            r_is_sb <= (storeCtrl == 3'b000);
        end else if (r_state == S_MERGE) begin
            r_data  <= w_merged;
        end
    end

    always_comb begin
        w_merged = mem_rdata;
        if (r_is_sb)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_data[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_data[15:0];
    end

    always_comb begin
        req_ready = (r_state == S_IDLE) && !rst;
        mem_re    = (r_state == S_READ);
        mem_we    = (r_state == S_WRITE);
        mem_addr  = (mem_re || mem_we) ? w_word_addr : '0;
        mem_wdata = mem_we ? r_data : 32'h0;
`ifdef STORE_MISALIGN_CHECK_EN
        err       = (r_state == S_FAIL);
`else
        err       = 1'b0;
`endif
        done      = mem_we || err;
    end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  storeCtrl;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];

    store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .storeCtrl(storeCtrl), .addr(addr), .wd(wd), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory: one-cycle read latency, write on strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= tb_mem[mem_addr[11:2]];
        if (mem_we) tb_mem[mem_addr[11:2]] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 = direct word write, 1 = read-modify-write, 2 = rejected
    function automatic int classify(input logic [2:0] c, input logic [31:0] a);
`ifdef STORE_MISALIGN_CHECK_EN
        if (c > 3'd2) return 2;
        if (c == 3'd1 && (a % 2) != 0) return 2;
        if (c == 3'd2 && (a % 4) != 0) return 2;
`endif
        if (c == 3'd0 || c == 3'd1) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] c, input logic [31:0] a,
                                               input logic [31:0] old, input logic [31:0] d);
        int sh;
        if (c == 3'd0) begin
            sh = 8 * (a % 4);
            return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end
        if (c == 3'd1) begin
            sh = 16 * ((a / 2) % 2);
            return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic start(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready_wait"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        storeCtrl = c;
        addr      = a;
        wd        = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge of cycle N+1; checks every cycle until ready returns.
    task automatic follow(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, input logic [2:0] hc, input logic [31:0] ha, input logic [31:0] hd);
        int cls, len;
        logic [31:0] exp_w, al;
        bit e_re, e_we, e_err;
        cls   = classify(c, a);
        al    = a & 32'hFFFF_FFFC;
        exp_w = model_word(c, a, ref_mem[a[11:2]], d);
        len   = (cls == 1) ? 4 : 2;
        req_valid = hold;
        storeCtrl = hold ? hc : 3'($urandom);
        addr      = hold ? ha : $urandom;
        wd        = hold ? hd : $urandom;
        for (int k = 1; k <= len; k++) begin
            e_re  = (cls == 1) && (k == 1);
            e_we  = ((cls == 0) && (k == 1)) || ((cls == 1) && (k == 3));
            e_err = (cls == 2) && (k == 1);
            chk($sformatf("%s c%0d mem_re", tag, k),    {31'b0, mem_re},    {31'b0, e_re});
            chk($sformatf("%s c%0d mem_we", tag, k),    {31'b0, mem_we},    {31'b0, e_we});
            chk($sformatf("%s c%0d done", tag, k),      {31'b0, done},      {31'b0, e_we || e_err});
            chk($sformatf("%s c%0d err", tag, k),       {31'b0, err},       {31'b0, e_err});
            chk($sformatf("%s c%0d req_ready", tag, k), {31'b0, req_ready}, {31'b0, k == len});
            chk($sformatf("%s c%0d mem_addr", tag, k),  mem_addr,  (e_re || e_we) ? al : 32'h0);
            chk($sformatf("%s c%0d mem_wdata", tag, k), mem_wdata, e_we ? exp_w : 32'h0);
            if (k < len) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (cls != 2) ref_mem[a[11:2]] = exp_w;
    endtask

    task automatic store(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        start(tag, c, a, d);
        follow(tag, c, a, d, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        logic [2:0]  rc;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        tb_mem[32'h203 >> 2]  = 32'h1122_3344; ref_mem[32'h203 >> 2] = 32'h1122_3344;
        tb_mem[32'h302 >> 2]  = 32'h5566_7788; ref_mem[32'h302 >> 2] = 32'h5566_7788;
        rst = 1'b1; req_valid = 1'b0; storeCtrl = 3'd0; addr = 32'h0; wd = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst mem_re",    {31'b0, mem_re},    32'd0);
        chk("rst mem_we",    {31'b0, mem_we},    32'd0);
        chk("rst done",      {31'b0, done},      32'd0);
        chk("rst err",       {31'b0, err},       32'd0);
        chk("rst mem_addr",  mem_addr,  32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("post-rst req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        // Directed stores
        store("sw104",  3'd2, 32'h0000_0104, 32'hDEAD_BEEF);
        store("sb203",  3'd0, 32'h0000_0203, 32'h0000_00AB);
        chk("sb203 word", ref_mem[32'h203 >> 2], 32'hAB22_3344);
        store("sh302",  3'd1, 32'h0000_0302, 32'hFFFF_CAFE);
        chk("sh302 word", ref_mem[32'h302 >> 2], 32'hCAFE_7788);
        store("sh300",  3'd1, 32'h0000_0300, 32'hFFFF_CAFE);
        chk("sh300 word", ref_mem[32'h300 >> 2], 32'hCAFE_CAFE);
        store("sw101",  3'd2, 32'h0000_0101, 32'h0BAD_F00D);
        store("sh105",  3'd1, 32'h0000_0105, 32'h0000_1234);
        store("ill110", 3'd7, 32'h0000_0110, 32'h7777_0000);

        // Request held while busy: the second is taken only when ready returns
        start("busy1", 3'd0, 32'h0000_0205, 32'h0000_005A);
        follow("busy1", 3'd0, 32'h0000_0205, 32'h0000_005A, 1'b1, 3'd2, 32'h0000_0208, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        follow("busy2", 3'd2, 32'h0000_0208, 32'h1234_5678, 1'b0, 3'd0, 32'h0, 32'h0);

        // Reset during MERGE of an sb
        start("rstmid", 3'd0, 32'h0000_0401, 32'h0000_00EE);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid mem_we",    {31'b0, mem_we},    32'd0);
        chk("rstmid mem_re",    {31'b0, mem_re},    32'd0);
        chk("rstmid req_ready", {31'b0, req_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid hold%0d mem_we", k), {31'b0, mem_we}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rstmid ready after", {31'b0, req_ready}, 32'd1);
        chk("rstmid word intact", tb_mem[32'h401 >> 2], ref_mem[32'h401 >> 2]);
        @(negedge clk);
        store("rstmid sw", 3'd2, 32'h0000_0400, 32'hA5A5_5A5A);

        // Randomized stores into a small window so words are revisited
        for (int i = 0; i < 40; i++) begin
            rc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            store($sformatf("rnd%0d", i), rc, 32'h800 + $urandom_range(0, 63), $urandom);
        end

        for (int i = 0; i < 16; i++)
            chk($sformatf("mem word %0d", i), tb_mem[(32'h800 >> 2) + i], ref_mem[(32'h800 >> 2) + i]);
        chk("mem word 104", tb_mem[32'h104 >> 2], ref_mem[32'h104 >> 2]);
        chk("mem word 200", tb_mem[32'h200 >> 2], ref_mem[32'h200 >> 2]);
        chk("mem word 300", tb_mem[32'h300 >> 2], ref_mem[32'h300 >> 2]);
        chk("mem word 100", tb_mem[32'h100 >> 2], ref_mem[32'h100 >> 2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Store-side counterpart of the load extension unit. Takes a store request (sb/sh/sw funct3 code, byte address, rs2 data) from the datapath and performs the write into a word-wide data memory that has no byte enables. Full-word stores write directly; byte and halfword stores perform a read-modify-write sequence. Sits between the execute stage and the data memory port and stalls the core via `req_ready` while busy.

## Interface
- `ADDR_W`, default 32, byte-address width; `mem_addr` carries the same width.
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  store request present
- `req_ready`  out  1  unit can accept a request this cycle
- `storeCtrl`  in  3  funct3: 000 sb, 001 sh, 010 sw; other codes are illegal
- `addr`  in  ADDR_W  byte address of the store
- `wd`  in  32  store data (rs2)
- `mem_addr`  out  ADDR_W  word-aligned address, with bits [1:0] = 00
- `mem_re`  out  1  memory read strobe; data is returned on `mem_rdata` one cycle later
- `mem_rdata`  in  32  memory read data
- `mem_we`  out  1  memory write strobe, one cycle per store
- `mem_wdata`  out  32  full word to write
- `done`  out  1  one-cycle pulse when the store completes or is rejected
- `err`  out  1  one-cycle pulse, coincident with `done`, for a misaligned or illegal request

## Operation
- **Handshake:** a request is accepted when `req_valid && req_ready`. The unit latches `storeCtrl`, `addr` and `wd` on acceptance. `req_ready` is 1 only in the IDLE state and is 0 while `rst` is high.
- **States:** IDLE, READ, MERGE, WRITE, FAIL.
  - IDLE to WRITE: accept with sw.
  - IDLE to READ: accept with sb or sh.
  - IDLE to FAIL: accept with an illegal code, sh with addr[0]=1, or sw with addr[1:0]≠00.
  - READ to MERGE to WRITE to IDLE.
  - FAIL to IDLE.
- **READ:** `mem_re`=1 and `mem_addr`={addr[ADDR_W-1:2],2'b00}.
- **MERGE:** captures `mem_rdata` and computes the merged word in a register, little-endian.
  - sb replaces byte lane addr[1:0] with wd[7:0].
  - sh replaces halfword lane addr[1] with wd[15:0].
  - All other bits keep their read values.
- **WRITE:** `mem_we`=1 with `mem_addr` as above and `mem_wdata` set to the merged word (sw: wd unmodified). `done`=1 in this cycle.
- **FAIL:** `done`=1 and `err`=1. No `mem_re` or `mem_we` is issued.
- All memory-side outputs, `done` and `err` are decoded from registered state and registered data. They are glitch-free and 0 in every state not listed above.
- `req_valid` while busy is ignored; the requester must hold the request until `req_ready`.

## Timing
- **Reset values:** state IDLE; `mem_re`, `mem_we`, `done`, `err` = 0; `mem_addr`, `mem_wdata` = 0; `req_ready` = 0 while `rst` is high, then 1.
- **sw:** accepted at edge N; `mem_we`/`done` are high in cycle N+1; `req_ready` returns to 1 in cycle N+2.
- **sb/sh:** accepted at edge N; `mem_re` in cycle N+1, MERGE in N+2, `mem_we`/`done` in N+3, ready in N+4.
- **Rejected request:** `done`/`err` in cycle N+1, ready in N+2.
- **Back-to-back:** one store completes per 2 cycles (sw) or 4 cycles (sb/sh); there is no overlap.
- **Reset mid-operation:** state forced to IDLE asynchronously and `mem_re`/`mem_we` drop at once. No partial write is issued and the latched request is discarded.
- **Same-word consecutive stores:** each store's READ occurs after the previous store's WRITE, so merges are always based on current memory contents.

## Configuration
- Macro `STORE_MISALIGN_CHECK_EN`.
- **Defined:** misaligned sh/sw and illegal codes go to FAIL as described above.
- **Undefined:**
  - FAIL is removed and `err` is tied to 0.
  - Misaligned sh uses lane addr[1]; misaligned sw writes the aligned word.
  - Illegal codes are treated as sw.

## Test plan
- **Reset then sw:** reset, then sw addr=0x0000_0104, wd=0xDEADBEEF → cycle N+1 shows `mem_we`=1, `mem_addr`=0x104, `mem_wdata`=0xDEADBEEF, `done`=1, and `mem_re` is never asserted.
- **sb:** sb addr=0x0000_0203, wd=0x0000_00AB, memory word 0x11223344 → `mem_re` in N+1 at 0x200; `mem_wdata`=0xAB223344 with `done` in N+3.
- **sh:** sh addr=0x0000_0302, wd=0xFFFF_CAFE, memory word 0x55667788 → `mem_wdata`=0xCAFE7788; then sh at 0x300 → 0xCAFECAFE.
- **Misaligned (macro defined):** sw addr=0x0000_0101 → `done`=`err`=1 in N+1 with no `mem_re`/`mem_we`. With the macro undefined, the same request writes `mem_addr`=0x100.
- **Request while busy:** `req_valid` held during an sb → second request accepted only when `req_ready`=1 (N+4) and completes normally.
- **Reset mid-operation:** `rst` asserted during MERGE of an sb → `mem_we` never pulses; after release, `req_ready`=1 and a new sw completes in 1 cycle.
